// File: rtl/tw_addr_sched_nwc_if.sv
// Twiddle-address scheduler bus.
// The master side (polynomial input controller) drives start, mode_intt, num_poly and in_valid.
// The slave side (scheduler) returns:
//   in_ready    - pair handshake
//   raddr       - per-stage ROM addresses, LOGN-1 bits per field
//   stage_vld   - per-stage valid flags
//   tw_sel_intt - ROM bank select
//   busy, done  - batch status
interface tw_addr_sched_nwc_if #(
    parameter int LOGN = 4,
    parameter int CNTW = 8
);
    logic                       start;
    logic                       mode_intt;
    logic [CNTW-1:0]            num_poly;
    logic                       in_valid;
    logic                       in_ready;
    logic [LOGN*(LOGN-1)-1:0]   raddr;
    logic [LOGN-1:0]            stage_vld;
    logic                       tw_sel_intt;
    logic                       busy;
    logic                       done;

    modport master (
        output start, mode_intt, num_poly, in_valid,
        input  in_ready, raddr, stage_vld, tw_sel_intt, busy, done
    );

    modport slave (
        input  start, mode_intt, num_poly, in_valid,
        output in_ready, raddr, stage_vld, tw_sel_intt, busy, done
    );
endinterface

// File: rtl/tw_addr_sched_nwc.sv
// Twiddle-address scheduler for the radix-2 MDC NTT/INTT pipeline.
// Every pair accepted at stage 0 is stamped with its in-polynomial index k. The index then
// travels down a non-stalling valid+index delay line, which is tapped every STAGE_LAT cycles.
// Stage s gets ROM address k >> (LOGN-1-s), i.e. the top s bits of k.
// Ports: clk, rst_n (async active-low), bus (slave modport of tw_addr_sched_nwc_if).
//
// state | meaning
// IDLE  | waiting for start with non-zero num_poly
// RUN   | accepting pairs (in_ready = 1)
// DRAIN | input closed, last pair still travelling to stage LOGN-1
// DONE  | one-cycle done pulse, then back to IDLE
module tw_addr_sched_nwc #(
    parameter int LOGN      = 4,
    parameter int STAGE_LAT = 3,
    parameter int CNTW      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    tw_addr_sched_nwc_if.slave  bus
);
    localparam int PW    = LOGN - 1;
    localparam int DEPTH = (LOGN - 1) * STAGE_LAT;
    localparam int TW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pair_cnt;
    logic [CNTW-1:0] poly_cnt;
    logic [CNTW-1:0] num_poly_q;
    logic [TW-1:0]   drain_tmr;
    logic            start_ok, accept, last_accept;
    logic            in_ready_c, busy_c, done_c;

    logic [DEPTH-1:0]       dl_vld;
    logic [PW-1:0]          dl_idx [DEPTH];
    logic [LOGN-1:0]        tap_vld;
    logic [PW-1:0]          tap_idx [LOGN];
    logic [LOGN-1:0]        stage_vld_q;
    logic [LOGN*PW-1:0]     raddr_q;
    logic                   tw_sel_q;

    assign start_ok    = (state == S_IDLE) && bus.start && (bus.num_poly != '0);
    assign accept      = bus.in_valid && in_ready_c;
    // pair_cnt is exactly LOGN-1 bits, so the all-ones index is pair P-1
    assign last_accept = accept && (pair_cnt == {PW{1'b1}})
                         && (poly_cnt == num_poly_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok)           state_nxt = S_RUN;
            S_RUN:   if (last_accept)        state_nxt = S_DRAIN;
            S_DRAIN: if (drain_tmr == '0)    state_nxt = S_DONE;
            S_DONE:                          state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            S_RUN:   begin in_ready_c = 1'b1; busy_c = 1'b1; end
            S_DRAIN: busy_c = 1'b1;
            S_DONE:  done_c = 1'b1;
            default: ;
        endcase
    end

    // Drain timer is loaded with the delay-line depth on the last accept; reaching zero
    // means the last pair has just been registered on stage LOGN-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt   <= '0;
            poly_cnt   <= '0;
            num_poly_q <= '0;
            drain_tmr  <= '0;
        end else begin
            if (start_ok) begin
                pair_cnt   <= '0;
                poly_cnt   <= '0;
                num_poly_q <= bus.num_poly;
            end else if (accept) begin
                pair_cnt <= pair_cnt + 1'b1;
                if (pair_cnt == {PW{1'b1}}) poly_cnt <= poly_cnt + 1'b1;
            end
            if (last_accept)
                drain_tmr <= TW'(DEPTH);
            else if (state == S_DRAIN && drain_tmr != '0)
                drain_tmr <= drain_tmr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld <= '0;
            for (int i = 0; i < DEPTH; i++) dl_idx[i] <= '0;
        end else begin
            dl_vld[0] <= accept;
            dl_idx[0] <= pair_cnt;
            for (int i = 1; i < DEPTH; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

    // Stage 0 registers on the accept edge itself; stage s reads the slot written
    // s*STAGE_LAT-1 edges after the accept.
    assign tap_vld[0] = accept;
    assign tap_idx[0] = pair_cnt;
    for (genvar s = 1; s < LOGN; s++) begin : g_tap
        assign tap_vld[s] = dl_vld[s*STAGE_LAT-1];
        assign tap_idx[s] = dl_idx[s*STAGE_LAT-1];
    end

    // Field 0 is never written: the stage-0 address is always zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_q <= '0;
            raddr_q     <= '0;
            tw_sel_q    <= 1'b0;
        end else begin
            if (start_ok) tw_sel_q <= bus.mode_intt;
            stage_vld_q <= tap_vld;
            for (int s = 1; s < LOGN; s++)
                if (tap_vld[s]) raddr_q[s*PW +: PW] <= tap_idx[s] >> (PW - s);
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.stage_vld   = stage_vld_q;
    assign bus.raddr       = raddr_q;
    assign bus.tw_sel_intt = tw_sel_q;
endmodule

// File: tb/tb_tw_addr_sched_nwc.sv
module tb_tw_addr_sched_nwc;
    localparam int LOGN = 4, L = 3, CNTW = 8, PW = 3, P = 8, D = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tw_addr_sched_nwc_if #(.LOGN(LOGN), .CNTW(CNTW)) bus ();
    tw_addr_sched_nwc #(.LOGN(LOGN), .STAGE_LAT(L), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0, bad = 0;

    // Timeline model: which edge accepted which pair index; stage s shows edge e's pair at e+s*L.
    int  ecnt;
    bit  acc_at [16384];
    int  k_at   [16384];
    bit  m_idle, m_busy, m_ready, m_mode, m_done;
    int  m_done_edge, m_target, m_acc;
    logic [LOGN-1:0]    e_vld;
    logic [LOGN*PW-1:0] e_raddr;

    // Observations of the DUT for timing checks
    logic prev_ready;
    int   dut_last_acc, dut_done_edge, dut_nacc;

    function automatic void m_reset();
        foreach (acc_at[i]) begin acc_at[i] = 1'b0; k_at[i] = 0; end
        ecnt = 0; m_idle = 1; m_busy = 0; m_ready = 0; m_mode = 0; m_done = 0;
        m_done_edge = -1; m_target = 0; m_acc = 0;
        e_vld = '0; e_raddr = '0; prev_ready = 1'b0;
    endfunction

    task automatic drive(input bit st, input bit md, input int np, input bit v);
        bus.start = st; bus.mode_intt = md; bus.num_poly = CNTW'(np); bus.in_valid = v;
    endtask

    task automatic tick();
        bit acc, was_idle, was_done;
        int cur, e;
        @(posedge clk);
        cur = ecnt;
        if (prev_ready && bus.in_valid) begin dut_last_acc = cur; dut_nacc++; end
        was_idle = m_idle; was_done = m_done;
        acc = m_ready && bus.in_valid;
        acc_at[cur] = acc;
        k_at[cur] = m_acc % P;
        if (acc) begin
            m_acc++;
            if (m_acc == m_target) begin m_ready = 0; m_done_edge = cur + D + 1; end
        end
        m_done = (cur == m_done_edge);
        if (m_done) m_busy = 0;
        if (was_done) m_idle = 1;
        if (was_idle && bus.start && bus.num_poly != 0) begin
            m_idle = 0; m_busy = 1; m_ready = 1; m_mode = bus.mode_intt;
            m_target = int'(bus.num_poly) * P; m_acc = 0;
        end
        for (int s = 0; s < LOGN; s++) begin
            e = cur - s * L;
            if (e >= 0 && acc_at[e]) begin
                e_vld[s] = 1'b1;
                if (s > 0) e_raddr[s*PW +: PW] = PW'(k_at[e] >> (PW - s));
            end else e_vld[s] = 1'b0;
        end
        ecnt++;
        #1;
        if (bus.done) dut_done_edge = cur;
        prev_ready = bus.in_ready;
    endtask

    task automatic test_reset();
        drive(1, 1, 2, 1);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.raddr !== '0) begin bad++; $display("FAIL reset_raddr got=%h exp=0", bus.raddr); end
        total++; if (bus.stage_vld !== '0) begin bad++; $display("FAIL reset_stage_vld got=%b exp=0", bus.stage_vld); end
        total++; if (bus.tw_sel_intt !== 1'b0) begin bad++; $display("FAIL reset_tw_sel got=%b exp=0", bus.tw_sel_intt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int v3 = 0, nd = 0;
        for (int n = 0; n < 30; n++) begin
            drive(n == 0, 0, 1, 1);
            tick();
            total++; if (bus.stage_vld !== e_vld) begin bad++; $display("FAIL single_vld e=%0d got=%b exp=%b", ecnt-1, bus.stage_vld, e_vld); end
            total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL single_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
            total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL single_ready e=%0d got=%b exp=%b", ecnt-1, bus.in_ready, m_ready); end
            total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL single_busy e=%0d got=%b exp=%b", ecnt-1, bus.busy, m_busy); end
            total++; if (bus.done !== m_done) begin bad++; $display("FAIL single_done e=%0d got=%b exp=%b", ecnt-1, bus.done, m_done); end
            total++; if (bus.tw_sel_intt !== m_mode) begin bad++; $display("FAIL single_tw_sel e=%0d got=%b exp=%b", ecnt-1, bus.tw_sel_intt, m_mode); end
            if (bus.stage_vld[3]) v3++;
            if (bus.done) nd++;
        end
        total++; if (v3 !== 8) begin bad++; $display("FAIL single_vld3_count got=%0d exp=8", v3); end
        total++; if (nd !== 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", nd); end
        total++; if (dut_done_edge - dut_last_acc !== 10) begin bad++; $display("FAIL single_done_latency got=%0d exp=10", dut_done_edge - dut_last_acc); end
    endtask

    task automatic test_multi();
        int nd = 0;
        dut_nacc = 0;
        for (int n = 0; n < 45; n++) begin
            drive(n == 0, 1, 3, 1);
            tick();
            total++; if (bus.stage_vld !== e_vld) begin bad++; $display("FAIL multi_vld e=%0d got=%b exp=%b", ecnt-1, bus.stage_vld, e_vld); end
            total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL multi_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
            total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL multi_ready e=%0d got=%b exp=%b", ecnt-1, bus.in_ready, m_ready); end
            total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL multi_busy e=%0d got=%b exp=%b", ecnt-1, bus.busy, m_busy); end
            total++; if (bus.done !== m_done) begin bad++; $display("FAIL multi_done e=%0d got=%b exp=%b", ecnt-1, bus.done, m_done); end
            total++; if (bus.tw_sel_intt !== m_mode) begin bad++; $display("FAIL multi_tw_sel e=%0d got=%b exp=%b", ecnt-1, bus.tw_sel_intt, m_mode); end
            if (bus.done) nd++;
        end
        total++; if (dut_nacc !== 24) begin bad++; $display("FAIL multi_accepts got=%0d exp=24", dut_nacc); end
        total++; if (nd !== 1) begin bad++; $display("FAIL multi_done_count got=%0d exp=1", nd); end
    endtask

    task automatic test_gaps();
        bit pat [5] = '{1, 0, 1, 1, 0};
        for (int n = 0; n < 60; n++) begin
            drive(n == 0, 0, 2, pat[n % 5]);
            tick();
            total++; if (bus.stage_vld !== e_vld) begin bad++; $display("FAIL gaps_vld e=%0d got=%b exp=%b", ecnt-1, bus.stage_vld, e_vld); end
            total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL gaps_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
            total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL gaps_ready e=%0d got=%b exp=%b", ecnt-1, bus.in_ready, m_ready); end
            total++; if (bus.done !== m_done) begin bad++; $display("FAIL gaps_done e=%0d got=%b exp=%b", ecnt-1, bus.done, m_done); end
        end
    endtask

    task automatic test_ignored();
        for (int n = 0; n < 45; n++) begin
            if (n < 5)       drive(1, 1, 0, 1);
            else if (n == 6) drive(1, 0, 1, 1);
            else             drive(n % 4 == 0, 1, 5, 1);
            tick();
            total++; if (bus.stage_vld !== e_vld) begin bad++; $display("FAIL ign_vld e=%0d got=%b exp=%b", ecnt-1, bus.stage_vld, e_vld); end
            total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL ign_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
            total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL ign_ready e=%0d got=%b exp=%b", ecnt-1, bus.in_ready, m_ready); end
            total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL ign_busy e=%0d got=%b exp=%b", ecnt-1, bus.busy, m_busy); end
            total++; if (bus.done !== m_done) begin bad++; $display("FAIL ign_done e=%0d got=%b exp=%b", ecnt-1, bus.done, m_done); end
            total++; if (bus.tw_sel_intt !== m_mode) begin bad++; $display("FAIL ign_tw_sel e=%0d got=%b exp=%b", ecnt-1, bus.tw_sel_intt, m_mode); end
            if (n >= 30 && m_idle) break;
        end
        drive(0, 0, 0, 0);
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            bit md = 1'($urandom_range(0, 1));
            int np = int'($urandom_range(1, 3));
            bit finished = 0;
            for (int n = 0; n < 200; n++) begin
                if (n == 0) drive(1, md, np, 1'($urandom_range(0, 1)));
                else drive(($urandom % 8) == 0, 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 4)), ($urandom % 4) != 0);
                tick();
                total++; if (bus.stage_vld !== e_vld) begin bad++; $display("FAIL rand_vld e=%0d got=%b exp=%b", ecnt-1, bus.stage_vld, e_vld); end
                total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL rand_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
                total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL rand_ready e=%0d got=%b exp=%b", ecnt-1, bus.in_ready, m_ready); end
                total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL rand_busy e=%0d got=%b exp=%b", ecnt-1, bus.busy, m_busy); end
                total++; if (bus.done !== m_done) begin bad++; $display("FAIL rand_done e=%0d got=%b exp=%b", ecnt-1, bus.done, m_done); end
                total++; if (bus.tw_sel_intt !== m_mode) begin bad++; $display("FAIL rand_tw_sel e=%0d got=%b exp=%b", ecnt-1, bus.tw_sel_intt, m_mode); end
                if (n > 0 && m_idle) begin finished = 1; break; end
            end
            total++; if (!finished) begin bad++; $display("FAIL rand_timeout batch=%0d got=running exp=idle", b); end
            drive(0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 20 && m_acc < 4; n++) begin
            drive(n == 0, 1, 2, 1);
            tick();
            total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL mid_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.raddr !== '0) begin bad++; $display("FAIL mid_raddr_rst got=%h exp=0", bus.raddr); end
        total++; if (bus.stage_vld !== '0) begin bad++; $display("FAIL mid_stage_vld got=%b exp=0", bus.stage_vld); end
        total++; if (bus.tw_sel_intt !== 1'b0) begin bad++; $display("FAIL mid_tw_sel got=%b exp=0", bus.tw_sel_intt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b exp=0", bus.done); end
        m_reset();
        #1 rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            drive(n == 0, 0, 1, 1);
            tick();
            total++; if (bus.stage_vld !== e_vld) begin bad++; $display("FAIL post_vld e=%0d got=%b exp=%b", ecnt-1, bus.stage_vld, e_vld); end
            total++; if (bus.raddr !== e_raddr) begin bad++; $display("FAIL post_raddr e=%0d got=%h exp=%h", ecnt-1, bus.raddr, e_raddr); end
            total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL post_ready e=%0d got=%b exp=%b", ecnt-1, bus.in_ready, m_ready); end
            total++; if (bus.done !== m_done) begin bad++; $display("FAIL post_done e=%0d got=%b exp=%b", ecnt-1, bus.done, m_done); end
        end
    endtask

    initial begin
        dut_last_acc = 0; dut_done_edge = 0; dut_nacc = 0;
        test_reset();
        test_single();
        test_multi();
        test_gaps();
        test_ignored();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
